// File: rtl/cram_loader_pkg.sv
// Shared definitions for the code-RAM loader: FSM encodings and byte/word geometry.
package cram_loader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_READ    = 3'd3,
    ST_CHECK   = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  function automatic int bytes_per_word(input int data_width);
    return data_width / BYTE_W;
  endfunction

endpackage

// File: rtl/cram_loader_packer.sv
// Byte-to-word packer: shifts bytes in MSB-first and flags the byte that completes a word.
module cram_loader_packer
  import cram_loader_pkg::*;
#(
  parameter int p_data_width = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_clear,
  input  logic                    i_accept,
  input  logic [BYTE_W-1:0]       i_byte,
  output logic                    o_word_valid,
  output logic [p_data_width-1:0] o_word
);

  localparam int BPW   = bytes_per_word(p_data_width);
  localparam int CNT_W = $clog2(BPW + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BPW - 1);

  logic [p_data_width-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  // The completed word includes the byte being accepted this cycle.
  assign o_word       = (shift_q << BYTE_W) | p_data_width'(i_byte);
  assign o_word_valid = i_accept && (cnt_q == LAST);

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (i_clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (i_accept) begin
      shift_d = o_word;
      cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/cram_loader.sv
// Code-RAM loader: packs a byte stream into words and writes them from a base address.
// Optional write-then-readback verification is enabled with CRAM_LOADER_VERIFY_EN.
module cram_loader
  import cram_loader_pkg::*;
#(
  parameter int p_data_width    = 16,
  parameter int p_address_width = 10
) (
  input  logic                       i_w_clk,
  input  logic                       i_w_reset,
  input  logic                       i_w_start,
  input  logic [p_address_width-1:0] i_w_base_address,
  input  logic [p_address_width:0]   i_w_length,
  input  logic [BYTE_W-1:0]          i_w_byte,
  input  logic                       i_w_byte_valid,
  output logic                       o_r_byte_ready,
  output logic [p_data_width-1:0]    o_r_mem_in,
  output logic [p_address_width-1:0] o_r_mem_address,
  output logic                       o_r_mem_we,
  output logic                       o_r_mem_oe,
  input  logic [p_data_width-1:0]    i_w_mem_out,
  output logic                       o_r_busy,
  output logic                       o_r_done,
  output logic                       o_r_error
);

  localparam int AW = p_address_width;

  state_e                  state_q, state_d;
  logic [AW-1:0]           base_q, base_d;
  logic [AW:0]             length_q, length_d;
  logic [AW:0]             index_q, index_d;
  logic [AW-1:0]           mem_address_q, mem_address_d;
  logic [p_data_width-1:0] mem_in_q, mem_in_d;

  logic                    start_accept;
  logic                    byte_accept;
  logic                    word_valid;
  logic [p_data_width-1:0] word;
  logic [AW:0]             index_inc;
  logic                    last_word;

  assign byte_accept = (state_q == ST_COLLECT) && i_w_byte_valid;
  assign index_inc   = index_q + (AW + 1)'(1);
  assign last_word   = (index_inc == length_q);

  cram_loader_packer #(
    .p_data_width(p_data_width)
  ) u_packer (
    .i_clk       (i_w_clk),
    .i_reset     (i_w_reset),
    .i_clear     (start_accept),
    .i_accept    (byte_accept),
    .i_byte      (i_w_byte),
    .o_word_valid(word_valid),
    .o_word      (word)
  );

`ifdef CRAM_LOADER_VERIFY_EN
  logic error_q, error_d;
`endif

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    length_d      = length_q;
    index_d       = index_q;
    mem_address_d = mem_address_q;
    mem_in_d      = mem_in_q;
    start_accept  = 1'b0;
`ifdef CRAM_LOADER_VERIFY_EN
    error_d       = error_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_w_start) begin
          start_accept = 1'b1;
          base_d       = i_w_base_address;
          length_d     = i_w_length;
          index_d      = '0;
`ifdef CRAM_LOADER_VERIFY_EN
          error_d      = 1'b0;
`endif
          state_d      = (i_w_length == '0) ? ST_DONE : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        // Address and data are captured here so they are stable for the whole WRITE cycle.
        if (word_valid) begin
          mem_in_d      = word;
          mem_address_d = base_q + index_q[AW-1:0];
          state_d       = ST_WRITE;
        end
      end
`ifdef CRAM_LOADER_VERIFY_EN
      ST_WRITE: state_d = ST_READ;
      ST_READ:  state_d = ST_CHECK;
      ST_CHECK: begin
        if (i_w_mem_out != mem_in_q) error_d = 1'b1;
        index_d = index_inc;
        state_d = last_word ? ST_DONE : ST_COLLECT;
      end
`else
      ST_WRITE: begin
        index_d = index_inc;
        state_d = last_word ? ST_DONE : ST_COLLECT;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      length_q      <= '0;
      index_q       <= '0;
      mem_address_q <= '0;
      mem_in_q      <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      length_q      <= length_d;
      index_q       <= index_d;
      mem_address_q <= mem_address_d;
      mem_in_q      <= mem_in_d;
    end
  end

`ifdef CRAM_LOADER_VERIFY_EN
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) error_q <= 1'b0;
    else           error_q <= error_d;
  end

  assign o_r_mem_oe = (state_q == ST_READ);
  assign o_r_error  = error_q;
`else
  logic unused_mem_out;
  assign unused_mem_out = ^i_w_mem_out;
  assign o_r_mem_oe     = 1'b0;
  assign o_r_error      = 1'b0;
`endif

  assign o_r_byte_ready  = (state_q == ST_COLLECT);
  assign o_r_mem_we      = (state_q == ST_WRITE);
  assign o_r_busy        = (state_q != ST_IDLE);
  assign o_r_done        = (state_q == ST_DONE);
  assign o_r_mem_in      = mem_in_q;
  assign o_r_mem_address = mem_address_q;

endmodule

// File: tb/tb_cram_loader.sv
// Self-checking bench for cram_loader: job table, write scoreboard and hand-written corner cases.
module tb_cram_loader;

  localparam int DW = 16;
  localparam int AW = 10;
`ifdef CRAM_LOADER_VERIFY_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_in = '0;
  logic [AW:0]   len_in = '0;
  logic [7:0]    byte_in = '0;
  logic          byte_valid = 1'b0;
  logic          o_r_byte_ready, o_r_mem_we, o_r_mem_oe, o_r_busy, o_r_done, o_r_error;
  logic [DW-1:0] o_r_mem_in;
  logic [AW-1:0] o_r_mem_address;
  logic [DW-1:0] mem_out = '0;

  always #5 clk = ~clk;

  cram_loader #(.p_data_width(DW), .p_address_width(AW)) dut (
    .i_w_clk         (clk),
    .i_w_reset       (rst),
    .i_w_start       (start),
    .i_w_base_address(base_in),
    .i_w_length      (len_in),
    .i_w_byte        (byte_in),
    .i_w_byte_valid  (byte_valid),
    .o_r_byte_ready  (o_r_byte_ready),
    .o_r_mem_in      (o_r_mem_in),
    .o_r_mem_address (o_r_mem_address),
    .o_r_mem_we      (o_r_mem_we),
    .o_r_mem_oe      (o_r_mem_oe),
    .i_w_mem_out     (mem_out),
    .o_r_busy        (o_r_busy),
    .o_r_done        (o_r_done),
    .o_r_error       (o_r_error)
  );

  // RAM model with registered read and an optional corrupted readback address.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic          corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;

  always @(posedge clk) begin
    if (o_r_mem_we) ram[o_r_mem_address] <= o_r_mem_in;
    if (o_r_mem_oe && !o_r_mem_we)
      mem_out <= (corrupt_en && o_r_mem_address == corrupt_addr) ? 16'hDEAD : ram[o_r_mem_address];
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic [63:0]   bytes;
    int            gap;
    logic [AW-1:0] exp_last_addr;
  } vec_t;

  wr_t        sb[$];
  wr_t        mon_e;
  logic [7:0] byte_q[$];
  vec_t       vec[5];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Every write the DUT issues must match the oldest expected write.
  always @(negedge clk) begin
    if (o_r_mem_we) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h, required no write", o_r_mem_address, o_r_mem_in);
      end else begin
        mon_e = sb.pop_front();
        chk("write_addr", 32'(o_r_mem_address), 32'(mon_e.addr));
        chk("write_data", 32'(o_r_mem_in), 32'(mon_e.data));
        chk("oe_low_on_write", 32'(o_r_mem_oe), 0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!o_r_byte_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("byte_handshake", 32'(o_r_byte_ready), 1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic run_job(input logic [AW-1:0] base, input logic [AW:0] len, input int gap,
                         input logic exp_err);
    for (int i = 0; i < int'(len); i++)
      sb.push_back('{addr: base + AW'(i), data: {byte_q[2*i], byte_q[2*i+1]}});
    start   = 1'b1;
    base_in = base;
    len_in  = len;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(o_r_busy), 1);
    if (len != '0) begin
      for (int b = 0; b < 2 * int'(len); b++) begin
        send_byte(byte_q[b]);
        if (gap > 0 && b == 0) begin
          for (int k = 0; k < gap; k++) begin
            start   = (k == 2);
            base_in = '0;
            len_in  = 1;
            @(negedge clk);
            start = 1'b0;
            chk("busy_during_gap", 32'(o_r_busy), 1);
            chk("ready_during_gap", 32'(o_r_byte_ready), 1);
          end
        end
      end
      repeat (1 + EXTRA) @(negedge clk);
    end
    chk("done_pulse", 32'(o_r_done), 1);
    chk("ready_at_done", 32'(o_r_byte_ready), 0);
    chk("error_at_done", 32'(o_r_error), 32'(exp_err));
    @(negedge clk);
    chk("done_single", 32'(o_r_done), 0);
    chk("busy_after_done", 32'(o_r_busy), 0);
    chk("error_after_done", 32'(o_r_error), 32'(exp_err));
    chk("scoreboard_drained", 32'(sb.size()), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(o_r_byte_ready), 0);
    chk({tag, "_busy"}, 32'(o_r_busy), 0);
    chk({tag, "_done"}, 32'(o_r_done), 0);
    chk({tag, "_we"}, 32'(o_r_mem_we), 0);
    chk({tag, "_oe"}, 32'(o_r_mem_oe), 0);
    chk({tag, "_error"}, 32'(o_r_error), 0);
    chk({tag, "_addr"}, 32'(o_r_mem_address), 0);
    chk({tag, "_mem_in"}, 32'(o_r_mem_in), 0);
  endtask

  initial begin
    vec[0] = '{10'h010, 11'd2, 64'h1234_5678_0000_0000, 0, 10'h011};
    vec[1] = '{10'h000, 11'd0, 64'h0,                   0, 10'h011};
    vec[2] = '{10'h3FF, 11'd2, 64'hAABB_CCDD_0000_0000, 0, 10'h000};
    vec[3] = '{10'h100, 11'd2, 64'hCAFE_BEEF_0000_0000, 5, 10'h101};
    vec[4] = '{10'h200, 11'd4, 64'h0102_0304_0506_0708, 0, 10'h203};

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      byte_q.delete();
      for (int i = 0; i < 2 * int'(vec[v].len); i++)
        byte_q.push_back(vec[v].bytes[63-8*i -: 8]);
      run_job(vec[v].base, vec[v].len, vec[v].gap, 1'b0);
      chk("last_addr", 32'(o_r_mem_address), 32'(vec[v].exp_last_addr));
    end

    // Full-memory job starting mid-array: every address written once, wrapping at the top.
    byte_q.delete();
    for (int i = 0; i < 2048; i++) byte_q.push_back(8'($urandom_range(0, 255)));
    run_job(10'h155, 11'd1024, 0, 1'b0);
    chk("full_last_addr", 32'(o_r_mem_address), 32'h154);

    // Reset after the first byte of a word: nothing is written, the next job packs from the MSB.
    start   = 1'b1;
    base_in = 10'h020;
    len_in  = 11'd1;
    @(negedge clk);
    start      = 1'b0;
    byte_in    = 8'h99;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    chk("ready_mid_word", 32'(o_r_byte_ready), 1);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    byte_q.delete();
    byte_q.push_back(8'hAB);
    byte_q.push_back(8'hCD);
    run_job(10'h020, 11'd1, 0, 1'b0);
    chk("post_reset_word", 32'(o_r_mem_in), 32'hABCD);

`ifdef CRAM_LOADER_VERIFY_EN
    // Corrupted readback sets the sticky error; the next accepted start clears it.
    corrupt_en   = 1'b1;
    corrupt_addr = 10'h040;
    byte_q.delete();
    byte_q.push_back(8'h12);
    byte_q.push_back(8'h34);
    byte_q.push_back(8'h56);
    byte_q.push_back(8'h78);
    run_job(10'h040, 11'd2, 0, 1'b1);
    corrupt_en = 1'b0;
    byte_q.delete();
    run_job(10'h000, 11'd0, 0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required simulation to finish");
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/cram_loader.md
Name: cram_loader

Overview:
- Write-side initiator for the 16-bit code RAM.
- Accepts a byte stream on a valid/ready handshake and packs the bytes MSB-first into p_data_width-bit words.
- Drives the RAM's single port (data in, address, write enable, output enable) to store the words at consecutive addresses starting from a programmable base.
- Sits between a host byte source (UART RX or a test bench) and the RAM instance, so program images can be loaded at run time instead of from an initialisation file.

Parameters:
- p_data_width, 16, RAM word width; must be a multiple of 8.
- p_address_width, 10, RAM address width.
- Derived local constant: bytes per word = p_data_width/8.

Ports:
- i_w_clk  input  1  system clock; all logic on rising edge.
- i_w_reset  input  1  asynchronous, active-high reset.
- i_w_start  input  1  pulse; starts a load job when idle.
- i_w_base_address  input  p_address_width  first RAM address of the job; sampled on an accepted start.
- i_w_length  input  p_address_width+1  number of words to write (0 .. 2**p_address_width); sampled on an accepted start.
- i_w_byte  input  8  stream byte.
- i_w_byte_valid  input  1  i_w_byte is valid.
- o_r_byte_ready  output  1  loader accepts a byte this cycle.
- o_r_mem_in  output  p_data_width  word to the RAM data input.
- o_r_mem_address  output  p_address_width  RAM address.
- o_r_mem_we  output  1  RAM write enable.
- o_r_mem_oe  output  1  RAM output enable.
- i_w_mem_out  input  p_data_width  RAM read data; registered, valid the cycle after the address is presented with oe=1, we=0.
- o_r_busy  output  1  a job is in progress.
- o_r_done  output  1  one-cycle pulse at job completion.
- o_r_error  output  1  sticky verify-mismatch flag.

Behaviour:
- Reset (asynchronous, any state, including mid-job): all outputs go to 0 and the FSM returns to IDLE. The word counter and byte shift register clear. Any partially assembled word is discarded and not written.
- FSM states: IDLE, COLLECT, WRITE, READ, CHECK, DONE. READ and CHECK exist only with the optional feature.
- IDLE:
  - o_r_byte_ready=0; o_r_busy=0.
  - On i_w_start: latch base and length, clear o_r_error, clear the word index.
  - Length 0: go to DONE.
  - Otherwise: go to COLLECT.
- i_w_start outside IDLE is ignored.
- COLLECT:
  - o_r_byte_ready=1.
  - A byte is accepted on a cycle with i_w_byte_valid && o_r_byte_ready.
  - Bytes shift in MSB-first: the first accepted byte lands in bits [p_data_width-1 : p_data_width-8].
  - After the last byte of a word is accepted, go to WRITE. ready drops in the following cycle.
- WRITE (one cycle):
  - o_r_mem_we=1, o_r_mem_oe=0.
  - o_r_mem_address = (base + index) mod 2**p_address_width, so the address wraps past the top of memory.
  - o_r_mem_in = assembled word.
  - Next state: READ if the feature is enabled; otherwise index+1==length -> DONE, else COLLECT.
- DONE (one cycle): o_r_done=1; next state IDLE.
- o_r_busy=1 in every state except IDLE.
- Outside WRITE/READ: o_r_mem_we=0, o_r_mem_oe=0; o_r_mem_address and o_r_mem_in hold their last values.
- Timing without the feature:
  - Last byte of a word accepted in cycle N -> we=1 in cycle N+1.
  - For the final word, o_r_done=1 in cycle N+2.
  - Minimum cost is one cycle per byte plus one cycle per word.
- A full-memory job (length = 2**p_address_width) writes every address exactly once; the index counter is p_address_width+1 bits wide.
- Bytes arriving with valid=1 while ready=0 are not consumed; the source must hold them.

Optional Feature:
- Macro: CRAM_LOADER_VERIFY_EN.
- Defined: after WRITE, the FSM visits two more states.
  - READ: same address; o_r_mem_oe=1, o_r_mem_we=0.
  - CHECK: compare i_w_mem_out with the written word. On mismatch, set o_r_error (sticky until the next accepted start). Then go to DONE or COLLECT, using the same rule as WRITE.
  - Each word costs 2 extra cycles; a mismatch does not abort the job.
- Not defined: no READ/CHECK states; o_r_mem_oe and o_r_error are tied to 0; i_w_mem_out is unused.

Decomposition:
- Shared package/header holds:
  - FSM state encodings.
  - Bytes-per-word derivation.
  - Byte width constant (8).
- One natural sub-module: cram_loader_packer. It is the byte shift register plus a byte counter, and outputs word_valid and word.

Test Plan:
- Reset, then start base=0x010, length=2, bytes 12 34 56 78 streamed back-to-back -> writes 0x1234@0x010 and 0x5678@0x011; done pulses once, two cycles after the byte 78 handshake.
- Start with length=0 -> done pulse the cycle after start; we never asserted; ready never asserted.
- Base=0x3FF, length=2, bytes AA BB CC DD -> writes 0xAABB@0x3FF and 0xCCDD@0x000 (address wrap).
- Byte source drops valid between the two bytes of a word for 5 cycles; a second start pulse is issued mid-job -> word assembled correctly; second start ignored; busy stays high.
- Assert reset after one byte of a word -> all outputs 0 immediately; no write occurs; a new job afterwards packs from the MSB.
- With CRAM_LOADER_VERIFY_EN, force the RAM model to return 0xDEAD for the readback of a word written as 0x1234 -> o_r_error=1 and stays set through done; the next start clears it.
